// File: rtl/bit_frame_writer_if.sv
// Pixel-stream input and bit-frame RAM write port of bit_frame_writer.
// master = the writer (consumes pixels, drives RAM writes), slave = its environment.
interface bit_frame_writer_if #(
  parameter int rd_port_w = 16
);
  logic                 pix_valid;
  logic                 pix_bit;
  logic                 pix_sof;
  logic                 wr_en;
  logic [15:0]          wr_addr;
  logic [rd_port_w-1:0] wr_data;

  modport master (input pix_valid, pix_bit, pix_sof, output wr_en, wr_addr, wr_data);
  modport slave  (output pix_valid, pix_bit, pix_sof, input wr_en, wr_addr, wr_data);
endinterface

// File: rtl/bit_frame_writer.sv
// Packs a 1-bpp pixel stream LSB-first into ping-pong bit-frame RAM words; writes land 1 cycle after the completing pixel, no backpressure.
// Optional frames-written/frames-dropped counters: define BIT_FRAME_WRITER_STATS_EN.
module bit_frame_writer #(
  parameter int rd_port_w   = 16,
  parameter int bit_frame_w = 960,
  parameter int bit_frame_h = 540
) (
  input  logic               clk,
  input  logic               reset,
  bit_frame_writer_if.master bus,
  input  logic               bm_idle,
  input  logic               bm_working_buf,
  output logic [3:0]         img_number_out,
  output logic               frame_drop,
  output logic               frame_abort,
  output logic [15:0]        stat_frames_written,
  output logic [15:0]        stat_frames_dropped
);
  localparam int COL_W = (bit_frame_w > 1) ? $clog2(bit_frame_w) : 1;
  localparam int ROW_W = (bit_frame_h > 1) ? $clog2(bit_frame_h) : 1;
  localparam int BIT_W = (rd_port_w > 1) ? $clog2(rd_port_w) : 1;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(bit_frame_w - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(bit_frame_h - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(rd_port_w - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_WRITE, ST_DROP} state_t;

  state_t               state;
  logic [COL_W-1:0]     col;
  logic [ROW_W-1:0]     row;
  logic [BIT_W-1:0]     bit_cnt;
  logic [14:0]          word_addr;
  logic [rd_port_w-2:0] pack;
  logic                 commit_pending;

  logic                 sof, eff_wbuf, accept, take;
  logic [COL_W-1:0]     col_c;
  logic [ROW_W-1:0]     row_c;
  logic [BIT_W-1:0]     bit_c;
  logic [14:0]          word_c;
  logic [rd_port_w-1:0] pack_nxt;

  // The frame counter increments one cycle after the last write; an SOF in that
  // cycle must already see the new buffer, hence the pending-commit correction.
  always_comb begin
    sof      = bus.pix_valid && bus.pix_sof;
    eff_wbuf = img_number_out[0] ^ commit_pending;
    accept   = (bm_working_buf != eff_wbuf) || bm_idle;
    take     = bus.pix_valid && (sof ? accept : (state == ST_WRITE));
    col_c    = sof ? '0 : col;
    row_c    = sof ? '0 : row;
    bit_c    = sof ? '0 : bit_cnt;
    word_c   = sof ? '0 : word_addr;
    pack_nxt = {bus.pix_bit, pack};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= ST_IDLE;
      col            <= '0;
      row            <= '0;
      bit_cnt        <= '0;
      word_addr      <= '0;
      pack           <= '0;
      commit_pending <= 1'b0;
      img_number_out <= '0;
      frame_drop     <= 1'b0;
      frame_abort    <= 1'b0;
      bus.wr_en      <= 1'b0;
      bus.wr_addr    <= '0;
      bus.wr_data    <= '0;
    end else begin
      bus.wr_en   <= 1'b0;
      frame_drop  <= 1'b0;
      frame_abort <= 1'b0;

      if (commit_pending) begin
        img_number_out <= img_number_out + 4'd1;
        commit_pending <= 1'b0;
      end

      if (sof) begin
        if (state == ST_WRITE) frame_abort <= 1'b1;
        if (accept) begin
          state <= ST_WRITE;
        end else begin
          frame_drop <= 1'b1;
          state      <= ST_DROP;
        end
      end

      if (take) begin
        pack      <= pack_nxt[rd_port_w-1:1];
        word_addr <= word_c;
        if (bit_c == BIT_LAST) begin
          bus.wr_en   <= 1'b1;
          bus.wr_addr <= {eff_wbuf, word_c};
          bus.wr_data <= pack_nxt;
          word_addr   <= word_c + 15'd1;
          bit_cnt     <= '0;
        end else begin
          bit_cnt <= bit_c + BIT_W'(1);
        end

        if (col_c == COL_LAST) begin
          col <= '0;
          if (row_c == ROW_LAST) begin
            row            <= '0;
            state          <= ST_IDLE;
            commit_pending <= 1'b1;
          end else begin
            row <= row_c + ROW_W'(1);
          end
        end else begin
          col <= col_c + COL_W'(1);
          row <= row_c;
        end
      end
    end
  end

`ifdef BIT_FRAME_WRITER_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_frames_written <= '0;
      stat_frames_dropped <= '0;
    end else begin
      if (commit_pending) stat_frames_written <= stat_frames_written + 16'd1;
      if (sof && !accept) stat_frames_dropped <= stat_frames_dropped + 16'd1;
    end
  end
`else
  assign stat_frames_written = '0;
  assign stat_frames_dropped = '0;
`endif
endmodule

// File: tb/tb_bit_frame_writer.sv
// Directed + randomized bench for bit_frame_writer with a frame-level reference model.
module tb_bit_frame_writer;
  localparam int RW   = 16;
  localparam int FW   = 32;
  localparam int FH   = 4;
  localparam int WPR  = FW / RW;
  localparam int NPIX = FW * FH;

  logic        clk = 1'b0;
  logic        reset;
  logic        bm_idle, bm_working_buf;
  logic [3:0]  img_number_out;
  logic        frame_drop, frame_abort;
  logic [15:0] stat_w, stat_d;

  bit_frame_writer_if #(.rd_port_w(RW)) bus ();

  bit_frame_writer #(.rd_port_w(RW), .bit_frame_w(FW), .bit_frame_h(FH)) dut (
    .clk                 (clk),
    .reset               (reset),
    .bus                 (bus),
    .bm_idle             (bm_idle),
    .bm_working_buf      (bm_working_buf),
    .img_number_out      (img_number_out),
    .frame_drop          (frame_drop),
    .frame_abort         (frame_abort),
    .stat_frames_written (stat_w),
    .stat_frames_dropped (stat_d)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int wr_seen = 0;

  // Reference model: frame position, logical frame count and its visible copy.
  logic [3:0]    m_img, m_vis;
  logic [15:0]   m_written, m_dropped;
  bit            m_pend, m_writing, m_rst;
  int            m_pos;
  logic [RW-1:0] m_word;
  bit            e_wr, e_drop, e_abort;
  logic [15:0]   e_addr;
  logic [RW-1:0] e_data;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model(bit rst, bit v, bit b, bit s);
    int r, c;
    e_wr = 0; e_drop = 0; e_abort = 0; m_rst = rst;
    if (rst) begin
      m_img = 0; m_vis = 0; m_pend = 0; m_writing = 0;
      m_written = 0; m_dropped = 0; e_addr = 0; e_data = 0;
      return;
    end
    if (m_pend) begin
      m_vis = m_img; m_written++; m_pend = 0;
    end
    if (v && s) begin
      if (m_writing) e_abort = 1;
      if (bm_working_buf != m_img[0] || bm_idle) begin
        m_writing = 1; m_pos = 0;
      end else begin
        m_writing = 0; e_drop = 1; m_dropped++;
      end
    end
    if (v && m_writing) begin
      r = m_pos / FW;
      c = m_pos % FW;
      m_word[c % RW] = b;
      if (c % RW == RW - 1) begin
        e_wr   = 1;
        e_addr = {m_img[0], 15'(r * WPR + c / RW)};
        e_data = m_word;
      end
      if (m_pos == NPIX - 1) begin
        m_writing = 0; m_img = m_img + 4'd1; m_pend = 1;
      end
      m_pos++;
    end
  endtask

  task automatic compare();
    check("wr_en", bus.wr_en, e_wr);
    if (e_wr || m_rst) begin
      check("wr_addr", bus.wr_addr, e_addr);
      check("wr_data", bus.wr_data, e_data);
    end
    if (bus.wr_en) wr_seen++;
    check("frame_drop", frame_drop, e_drop);
    check("frame_abort", frame_abort, e_abort);
    check("img_number_out", img_number_out, m_vis);
`ifdef BIT_FRAME_WRITER_STATS_EN
    check("stat_written", stat_w, m_written);
    check("stat_dropped", stat_d, m_dropped);
`else
    check("stat_written_off", stat_w, 0);
    check("stat_dropped_off", stat_d, 0);
`endif
  endtask

  task automatic step(bit rst, bit v, bit b, bit s);
    @(negedge clk);
    reset = rst; bus.pix_valid = v; bus.pix_bit = b; bus.pix_sof = s;
    @(posedge clk);
    #1;
    model(rst, v, b, s);
    compare();
  endtask

  // mode 0: pix_bit = column LSB; mode 1: random bits. Idle gaps carry stray unqualified SOFs.
  task automatic send_frame(int npix, int mode, int gap_max);
    int g;
    for (int p = 0; p < npix; p++) begin
      g = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
      for (int k = 0; k < g; k++) step(0, 0, 1'($urandom), 1'($urandom));
      step(0, 1, (mode == 0) ? 1'((p % FW) & 1) : 1'($urandom), p == 0);
    end
  endtask

  initial begin
    reset = 1'b1; bus.pix_valid = 1'b0; bus.pix_bit = 1'b0; bus.pix_sof = 1'b0;
    bm_idle = 1'b1; bm_working_buf = 1'b0;
    m_img = 0; m_vis = 0; m_pend = 0; m_writing = 0; m_pos = 0; m_word = 0;
    m_written = 0; m_dropped = 0; e_addr = 0; e_data = 0;

    step(1, 0, 0, 0);
    step(1, 1, 1, 1);

    // Full frame, alternating pattern, back-to-back pixels
    wr_seen = 0;
    send_frame(NPIX, 0, 0);
    check("f1_last_data", bus.wr_data, 16'hAAAA);
    step(0, 0, 0, 0);
    check("f1_writes", wr_seen, 8);
    check("f1_img", img_number_out, 1);
    repeat (5) step(0, 1, 1, 0);

    // Second frame goes to buffer 1 while matcher busy on buffer 0
    bm_idle = 1'b0; bm_working_buf = 1'b0; wr_seen = 0;
    send_frame(NPIX, 1, 2);
    step(0, 0, 0, 0);
    check("f2_writes", wr_seen, 8);
    check("f2_img", img_number_out, 2);

    // Target buffer 0 still being matched: drop
    wr_seen = 0;
    send_frame(20, 1, 1);
    check("drop_writes", wr_seen, 0);
    check("drop_img", img_number_out, 2);
`ifdef BIT_FRAME_WRITER_STATS_EN
    check("stats_w_after3", stat_w, 2);
    check("stats_d_after3", stat_d, 1);
`endif
    bm_working_buf = 1'b1;
    send_frame(NPIX, 1, 0);

    // Abort at pixel 40, restart in the same buffer
    bm_idle = 1'b1; wr_seen = 0;
    send_frame(40, 1, 0);
    check("abort_old_writes", wr_seen, 2);
    send_frame(NPIX, 1, 0);

    // SOF right after last pixel uses the incremented buffer (now 0, busy)
    bm_idle = 1'b0; bm_working_buf = 1'b0;
    step(0, 1, 1, 1);
    check("b2b_drop", frame_drop, 1);
    step(0, 0, 0, 0);
    check("b2b_img", img_number_out, 4);

    // Reset mid-frame
    bm_idle = 1'b1;
    send_frame(70, 1, 0);
    step(1, 1, 0, 0);
    send_frame(NPIX, 1, 1);
    step(0, 0, 0, 0);
    check("post_reset_img", img_number_out, 1);

    // Random tail
    repeat (6) begin
      bm_idle = 1'($urandom); bm_working_buf = 1'($urandom);
      send_frame(int'($urandom_range(20, NPIX)), 1, 1);
    end
    repeat (3) step(0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
